// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART TX scheduler: state encoding, default
// UART data register address and acknowledge timeout, byte record type.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [31:0] UART_TX_ADDR_DEF = 32'h3000_0000;
    localparam int          ACK_TIMEOUT_DEF  = 16;
    localparam int          NUM_REQ          = 2;

    // One byte offered by a requester together with its end-of-message flag.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } tx_byte_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshakes plus UART write port of the TX scheduler.
// slave is the scheduler's view, master is the view of whoever drives it.
interface uart_tx_sched_if;

    logic        req0_valid_i;
    logic [7:0]  req0_data_i;
    logic        req0_last_i;
    logic        req0_ready_o;
    logic        req1_valid_i;
    logic [7:0]  req1_data_i;
    logic        req1_last_i;
    logic        req1_ready_o;
    logic        uart_busy_i;
    logic        uart_we_o;
    logic [31:0] uart_waddr_o;
    logic [31:0] uart_wdata_o;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic        err_timeout_o;

    modport slave (
        input  req0_valid_i, req0_data_i, req0_last_i,
        input  req1_valid_i, req1_data_i, req1_last_i,
        input  uart_busy_i,
        output req0_ready_o, req1_ready_o,
        output uart_we_o, uart_waddr_o, uart_wdata_o,
        output grant_o, busy_o, err_timeout_o
    );

    modport master (
        output req0_valid_i, req0_data_i, req0_last_i,
        output req1_valid_i, req1_data_i, req1_last_i,
        output uart_busy_i,
        input  req0_ready_o, req1_ready_o,
        input  uart_we_o, uart_waddr_o, uart_wdata_o,
        input  grant_o, busy_o, err_timeout_o
    );

endinterface

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter with message lock. The pointer remembers the
// requester served last; while locked only that requester may be granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       lock,
    output logic [1:0] gnt
);
    logic last_q;

    // Locked: owner only. Contention: the one not served last. Else pass through.
    always_comb begin
        gnt = 2'b00;
        if (lock)
            gnt = last_q ? {req[1], 1'b0} : {1'b0, req[0]};
        else if (&req)
            gnt = last_q ? 2'b01 : 2'b10;
        else
            gnt = req;
    end

    // Remember who was granted; reset value makes req0 win the first contention.
    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (|gnt)
            last_q <= gnt[1];
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules bytes from two requesters onto a single memory-mapped UART TX
// register: arbitrate, capture, strobe once, wait for the UART to take it.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter logic [31:0] UART_TX_ADDR = UART_TX_ADDR_DEF,
    parameter int          ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_sched_if.slave bus
);
    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t                    state_q, state_d;
    tx_byte_t                  byte_q;
    tx_byte_t [NUM_REQ-1:0]    req_byte;
    logic     [NUM_REQ-1:0]    req_valid, arb_req, gnt, grant_q;
    logic     [CNT_W-1:0]      cnt_q;
    logic                      lock_q, err_q, accept, timeout;

    assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};
    assign req_byte  = {{bus.req1_data_i, bus.req1_last_i},
                        {bus.req0_data_i, bus.req0_last_i}};

    // Requests are only presented while idle with the UART free, so a grant
    // is also the ready and the capture strobe.
    assign arb_req = req_valid & {NUM_REQ{state_q == S_IDLE && !bus.uart_busy_i}};
    assign accept  = |gnt;
    assign timeout = (state_q == S_WAIT_ACK) && !bus.uart_busy_i && (cnt_q == CNT_LAST);

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (arb_req),
        .lock (lock_q),
        .gnt  (gnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: capture, single strobe, wait for busy to rise then fall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_WRITE;
            S_WRITE:     state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (bus.uart_busy_i) state_d = S_WAIT_DONE;
                         else if (timeout)    state_d = S_IDLE;
            S_WAIT_DONE: if (!bus.uart_busy_i) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Captured byte, owner, message lock, ack counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q  <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                byte_q  <= gnt[1] ? req_byte[1] : req_byte[0];
                grant_q <= gnt;
                lock_q  <= gnt[1] ? !bus.req1_last_i : !bus.req0_last_i;
            end
            if (state_q == S_WRITE)
                cnt_q <= '0;
            else if (state_q == S_WAIT_ACK)
                cnt_q <= cnt_q + CNT_W'(1);
            // A lost acknowledge abandons the whole message, not just the byte.
            if (timeout) begin
                err_q   <= 1'b1;
                lock_q  <= 1'b0;
                grant_q <= '0;
            end
            // Ownership survives the return to idle only mid-message.
            if (state_q == S_WAIT_DONE && !bus.uart_busy_i && !lock_q)
                grant_q <= '0;
        end
    end

    assign bus.req0_ready_o  = gnt[0];
    assign bus.req1_ready_o  = gnt[1];
    assign bus.uart_we_o     = (state_q == S_WRITE);
    assign bus.uart_waddr_o  = bus.uart_we_o ? UART_TX_ADDR : 32'h0;
    assign bus.uart_wdata_o  = bus.uart_we_o ? {24'h0, byte_q.data} : 32'h0;
    assign bus.grant_o       = grant_q;
    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.err_timeout_o = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: reset/arbitration vector table, message-order
// scenarios and random traffic against a queue-level ordering model, and
// hand-written timeout, lock-stall and mid-operation reset sequences.
module tb_uart_tx_sched;
    import uart_tx_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_sched_if bus ();

    uart_tx_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [1:0] who;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic v0, v1, ub, r0, r1;
    } vec_t;

    int       tests = 0, fails = 0;
    int       cyc = 0;
    tx_byte_t q0[$], q1[$];
    bit       en0, en1;
    int       busy_len, busy_left;
    wr_t      log_q[$], exp_q[$];
    int       strobe_cyc[$];
    int       err_cyc;
    logic [2:0] err_snap;
    bit       ready_while_busy, both_ready, bad_bus, r1_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_env();
        q0.delete(); q1.delete(); log_q.delete(); exp_q.delete(); strobe_cyc.delete();
        en0 = 1'b1; en1 = 1'b1;
        busy_len = 0; busy_left = 0; err_cyc = -1; err_snap = '0;
        ready_while_busy = 1'b0; both_ready = 1'b0; bad_bus = 1'b0; r1_seen = 1'b0;
    endtask

    task automatic push(input int who, input logic [7:0] d, input logic l);
        tx_byte_t b;
        b.data = d; b.last = l;
        if (who == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    // Present queue heads and the modelled UART busy line.
    task automatic drive();
        bus.req0_valid_i = en0 && q0.size() > 0;
        bus.req0_data_i  = 8'h00; bus.req0_last_i = 1'b0;
        if (q0.size() > 0) begin bus.req0_data_i = q0[0].data; bus.req0_last_i = q0[0].last; end
        bus.req1_valid_i = en1 && q1.size() > 0;
        bus.req1_data_i  = 8'h00; bus.req1_last_i = 1'b0;
        if (q1.size() > 0) begin bus.req1_data_i = q1[0].data; bus.req1_last_i = q1[0].last; end
        bus.uart_busy_i = busy_left > 0;
        if (busy_left > 0) busy_left--;
    endtask

    // Observe the settled cycle: handshakes pop, strobes are logged.
    task automatic sample();
        if ((bus.req0_ready_o || bus.req1_ready_o) && bus.uart_busy_i) ready_while_busy = 1'b1;
        if (bus.req0_ready_o && bus.req1_ready_o) both_ready = 1'b1;
        if (bus.req1_ready_o) r1_seen = 1'b1;
        if (bus.err_timeout_o && err_cyc < 0) begin
            err_cyc  = cyc;
            err_snap = {bus.busy_o, bus.grant_o};
        end
        if (bus.req0_valid_i && bus.req0_ready_o) void'(q0.pop_front());
        if (bus.req1_valid_i && bus.req1_ready_o) void'(q1.pop_front());
        if (bus.uart_we_o) begin
            wr_t w;
            w.who = bus.grant_o; w.data = bus.uart_wdata_o[7:0];
            log_q.push_back(w);
            strobe_cyc.push_back(cyc);
            if (bus.uart_waddr_o != 32'h3000_0000 || bus.uart_wdata_o[31:8] != 24'h0) bad_bus = 1'b1;
            busy_left = busy_len;
        end else if ((bus.uart_waddr_o | bus.uart_wdata_o) != 32'h0) begin
            bad_bus = 1'b1;
        end
    endtask

    // One clock: starts and ends just after a rising edge.
    task automatic step();
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Expected write order: whole messages, alternating under contention,
    // req0 favoured first, a lone requester simply served.
    task automatic model();
        tx_byte_t a0[$] = q0;
        tx_byte_t a1[$] = q1;
        tx_byte_t b;
        bit  last_srv = 1'b1;
        int  who;
        wr_t w;
        exp_q.delete();
        while (a0.size() > 0 || a1.size() > 0) begin
            if (a0.size() > 0 && a1.size() > 0) who = last_srv ? 0 : 1;
            else                                who = (a0.size() > 0) ? 0 : 1;
            do begin
                b = (who == 1) ? a1.pop_front() : a0.pop_front();
                w.who = (who == 1) ? 2'b10 : 2'b01; w.data = b.data;
                exp_q.push_back(w);
            end while (!b.last);
            last_srv = (who == 1);
        end
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k = 0;
        while (log_q.size() < n && k < budget) begin step(); k++; end
        check({name, "_count"}, 32'(log_q.size()), 32'(n));
    endtask

    task automatic compare_exp(input string name);
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_wr%0d", name, i), 32'({log_q[i].who, log_q[i].data}),
                  32'({exp_q[i].who, exp_q[i].data}));
    endtask

    task automatic scen_flags(input string name);
        check({name, "_one_ready"}, 32'(both_ready), 32'h0);
        check({name, "_ready_vs_busy"}, 32'(ready_while_busy), 32'h0);
        check({name, "_bus_values"}, 32'(bad_bus), 32'h0);
    endtask

    function automatic wr_t mk(input logic [1:0] who, input logic [7:0] d);
        wr_t w;
        w.who = who; w.data = d;
        return w;
    endfunction

    logic [7:0] id_bytes [10];
    vec_t       vecs [7];
    int         nm, len;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        id_bytes = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h33, 8'h31, 8'h30, 8'h36, 8'h35, 8'h35};

        clear_env();
        drive();
        @(posedge clk);
        #1;

        // Reset state and idle arbitration straight out of reset.
        for (int i = 0; i < 7; i++) begin
            clear_env();
            pulse_rst();
            bus.req0_valid_i = vecs[i].v0; bus.req1_valid_i = vecs[i].v1;
            bus.uart_busy_i  = vecs[i].ub;
            #1;
            check($sformatf("vec%0d_ready", i), 32'({bus.req1_ready_o, bus.req0_ready_o}),
                  32'({vecs[i].r1, vecs[i].r0}));
            check($sformatf("vec%0d_status", i),
                  32'({bus.busy_o, bus.grant_o, bus.err_timeout_o, bus.uart_we_o}), 32'h0);
            check($sformatf("vec%0d_bus", i), bus.uart_waddr_o | bus.uart_wdata_o, 32'h0);
            bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0; bus.uart_busy_i = 1'b0;
        end

        // Locked ten-byte message from req0 while req1 waits with 0x41.
        clear_env(); pulse_rst(); busy_len = 3;
        for (int i = 0; i < 10; i++) push(0, id_bytes[i], i == 9);
        push(1, 8'h41, 1'b1);
        model();
        run_until(exp_q.size(), 600, "id_stream");
        compare_exp("id_stream");
        scen_flags("id_stream");

        // Single-byte messages alternate; UART busy for 8 cycles after each strobe.
        clear_env(); pulse_rst(); busy_len = 8;
        for (int i = 0; i < 4; i++) begin push(0, 8'hA0 + 8'(i), 1'b1); push(1, 8'hB0 + 8'(i), 1'b1); end
        model();
        run_until(exp_q.size(), 600, "alternate");
        compare_exp("alternate");
        scen_flags("alternate");
        if (strobe_cyc.size() >= 2)
            check("alternate_strobe_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd11);

        // Random message mixes and UART busy lengths.
        for (int r = 0; r < 4; r++) begin
            clear_env(); pulse_rst(); busy_len = $urandom_range(1, 8);
            for (int w = 0; w < 2; w++) begin
                nm = $urandom_range(1, 3);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) push(w, 8'($urandom), k == len - 1);
                end
            end
            model();
            run_until(exp_q.size(), 2000, $sformatf("rand%0d", r));
            compare_exp($sformatf("rand%0d", r));
            scen_flags($sformatf("rand%0d", r));
        end

        // UART never acknowledges: timeout timing, sticky flag, lock released.
        clear_env(); pulse_rst(); busy_len = 0;
        push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0); push(1, 8'h63, 1'b1);
        run_until(3, 300, "timeout");
        if (strobe_cyc.size() > 0)
            check("timeout_latency", 32'(err_cyc - strobe_cyc[0]), 32'd17);
        check("timeout_idle_nogrant", 32'(err_snap), 32'h0);
        check("timeout_sticky", 32'(bus.err_timeout_o), 32'h1);
        exp_q = '{mk(2'b01, 8'h61), mk(2'b10, 8'h63), mk(2'b01, 8'h62)};
        compare_exp("timeout");

        // Owner drops valid mid-message: stall with lock, req1 not served.
        clear_env(); pulse_rst(); busy_len = 2;
        push(0, 8'h58, 1'b0); push(0, 8'h59, 1'b1); push(1, 8'h5A, 1'b1);
        run_until(1, 50, "stall_first");
        en0 = 1'b0; r1_seen = 1'b0;
        repeat (20) step();
        check("stall_no_write", 32'(log_q.size()), 32'd1);
        check("stall_no_req1", 32'(r1_seen), 32'h0);
        check("stall_state", 32'({bus.busy_o, bus.grant_o}), 32'h1);
        en0 = 1'b1;
        run_until(3, 100, "stall_resume");
        exp_q = '{mk(2'b01, 8'h58), mk(2'b01, 8'h59), mk(2'b10, 8'h5A)};
        compare_exp("stall");
        scen_flags("stall");

        // Reset while waiting for the UART to finish a locked byte.
        clear_env(); pulse_rst(); busy_len = 8;
        push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b1); push(1, 8'h52, 1'b1);
        run_until(1, 50, "rstmid_first");
        repeat (4) step();
        check("rstmid_before", 32'({bus.busy_o, bus.grant_o}), 32'h5);
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; busy_left = 0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0; en1 = 1'b1;
        drive();
        #1;
        check("rstmid_status", 32'({bus.busy_o, bus.grant_o, bus.err_timeout_o}), 32'h0);
        check("rstmid_ready", 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'h2);
        @(negedge clk);
        check("rstmid_no_strobe", 32'(bus.uart_we_o), 32'h0);
        sample();
        @(posedge clk);
        #1;
        check("rstmid_req1_write", 32'({bus.uart_we_o, bus.grant_o, bus.uart_wdata_o[7:0]}),
              32'({1'b1, 2'b10, 8'h52}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
